// File: rtl/parking_pkg.sv
// Shared constants, types and helpers for the parking occupancy logic.
package parking_pkg;

  localparam int N_SPOTS_DEF = 8;

  // Width needed to hold a count from 0 to n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  typedef logic [N_SPOTS_DEF-1:0] bay_vec_t;

endpackage

// File: rtl/parking_popcount.sv
// Combinational ones-count of a bay occupancy vector.
// The gate controller uses this block as well.
module parking_popcount
  import parking_pkg::*;
#(
  parameter int N_SPOTS = N_SPOTS_DEF,
  parameter int CNT_W   = cnt_w(N_SPOTS)
) (
  input  logic [N_SPOTS-1:0] vec,
  output logic [CNT_W-1:0]   ones
);

  // Add up the set bits. Bit position does not affect the result.
  always_comb begin
    // NOTE: assigning a default before the loop means every path drives
    // ones, so no latch is inferred.
    ones = '0;
    for (int i = 0; i < N_SPOTS; i++) begin
      ones = ones + CNT_W'(vec[i]);
    end
  end

endmodule

// File: rtl/parking_capacity_cnt.sv
// Occupancy counter for a parking lot. Each bay sensor bit is
// synchronised, the occupied bays are counted, and the counts and
// status flags are registered.
module parking_capacity_cnt
  import parking_pkg::*;
#(
  parameter int N_SPOTS = N_SPOTS_DEF,
  parameter int CNT_W   = cnt_w(N_SPOTS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_SPOTS-1:0] new_capacity,
  output logic [CNT_W-1:0]   parked,
  output logic [CNT_W-1:0]   empty,
  output logic               full,
  output logic               all_free,
  output logic               changed
);

  localparam logic [CNT_W-1:0] SPOTS = CNT_W'(N_SPOTS);

  logic [N_SPOTS-1:0] sync_q1;
  logic [N_SPOTS-1:0] occ_s;
  logic [CNT_W-1:0]   cnt;

  // Two-flop synchroniser for each sensor bit. The sensors are not
  // related to clk in any way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      occ_s   <= '0;
    end else begin
      // NOTE: non-blocking assignments let occ_s take the old sync_q1,
      // which keeps the two stages separate.
      sync_q1 <= new_capacity;
      occ_s   <= sync_q1;
    end
  end

  parking_popcount #(
    .N_SPOTS (N_SPOTS),
    .CNT_W   (CNT_W)
  ) u_popcount (
    .vec  (occ_s),
    .ones (cnt)
  );

  // Register the counts and flags so the outputs come straight from flops
  // and cannot glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the reset values keep parked + empty == N_SPOTS and keep
      // full/all_free exclusive even while reset is held.
      parked   <= '0;
      empty    <= SPOTS;
      full     <= 1'b0;
      all_free <= 1'b1;
      changed  <= 1'b0;
    end else begin
      parked   <= cnt;
      empty    <= SPOTS - cnt;
      full     <= (cnt == SPOTS);
      all_free <= (cnt == '0);
      changed  <= (cnt != parked);
    end
  end

endmodule

// File: tb/tb_parking_capacity_cnt.sv
// Self-checking bench for parking_capacity_cnt (8 bays).
module tb_parking_capacity_cnt;
  import parking_pkg::*;

  localparam int NB = 8;

  logic       clk;
  logic       rst_n;
  bay_vec_t   new_capacity;
  logic [3:0] parked;
  logic [3:0] empty;
  logic       full;
  logic       all_free;
  logic       changed;

  parking_capacity_cnt #(.N_SPOTS(NB), .CNT_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .new_capacity (new_capacity),
    .parked       (parked),
    .empty        (empty),
    .full         (full),
    .all_free     (all_free),
    .changed      (changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;
  int exp_q[$];
  int prev_exp;
  int pulses;

  typedef struct {
    logic [7:0] vec;
    int         exp_parked;
    int         exp_empty;
  } vec_rec_t;

  vec_rec_t sweep[9];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare every output against the value the scoreboard predicts.
  task automatic check_outputs(input int e);
    check("parked", int'(parked), e);
    check("empty", int'(empty), NB - e);
    check("full", int'(full), int'(e == NB));
    check("all_free", int'(all_free), int'(e == 0));
    check("changed", int'(changed), int'(e != prev_exp));
    check("sum_invariant", int'(parked) + int'(empty), NB);
    check("flags_exclusive", int'(full && all_free), 0);
    prev_exp = e;
  endtask

  // Drive one vector for one cycle (from the falling edge). Its expected
  // count surfaces three rising edges later, which is when it is popped.
  task automatic step(input logic [7:0] v);
    new_capacity = v;
    exp_q.push_back($countones(v));
    @(posedge clk);
    @(negedge clk);
    if (changed) pulses++;
    if (exp_q.size() == 3) check_outputs(exp_q.pop_front());
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_parked"}, int'(parked), 0);
    check({tag, "_empty"}, int'(empty), NB);
    check({tag, "_full"}, int'(full), 0);
    check({tag, "_all_free"}, int'(all_free), 1);
    check({tag, "_changed"}, int'(changed), 0);
  endtask

  // Scoreboard restarts empty after reset: pipeline is flushed to zero.
  task automatic restart_scoreboard();
    exp_q.delete();
    prev_exp = 0;
    pulses   = 0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    sweep[0] = '{8'hF0, 4, 4};
    sweep[1] = '{8'h01, 1, 7};
    sweep[2] = '{8'h03, 2, 6};
    sweep[3] = '{8'h07, 3, 5};
    sweep[4] = '{8'h0F, 4, 4};
    sweep[5] = '{8'h1F, 5, 3};
    sweep[6] = '{8'h3F, 6, 2};
    sweep[7] = '{8'h7F, 7, 1};
    sweep[8] = '{8'hFF, 8, 0};

    // Reset held with all bays occupied.
    rst_n        = 1'b0;
    new_capacity = 8'hFF;
    repeat (3) @(negedge clk);
    check_reset_state("rst_hold");

    // Release: full after three edges, changed pulses once.
    rst_n = 1'b1;
    restart_scoreboard();
    repeat (6) step(8'hFF);
    check("rst_release_parked", int'(parked), 8);
    check("rst_release_full", int'(full), 1);
    check("rst_release_pulses", pulses, 1);

    // Fill sweep from the table.
    foreach (sweep[i]) begin
      repeat (10) step(sweep[i].vec);
      check($sformatf("sweep%0d_parked", i), int'(parked), sweep[i].exp_parked);
      check($sformatf("sweep%0d_empty", i), int'(empty), sweep[i].exp_empty);
    end

    // Non-contiguous input, then a bay swap with the same count.
    repeat (6) step(8'hA5);
    check("a5_parked", int'(parked), 4);
    pulses = 0;
    repeat (6) step(8'h5A);
    check("swap_parked", int'(parked), 4);
    check("swap_no_pulse", pulses, 0);

    // Swap of a single bay, 0x01 -> 0x02.
    repeat (6) step(8'h01);
    pulses = 0;
    repeat (6) step(8'h02);
    check("swap1_no_pulse", pulses, 0);

    // Jump from empty to full in one cycle; the scoreboard rejects any
    // intermediate value and checks both flags on the same edge.
    repeat (6) step(8'h00);
    check("jump_all_free_before", int'(all_free), 1);
    pulses = 0;
    repeat (6) step(8'hFF);
    check("jump_full_after", int'(full), 1);
    check("jump_all_free_after", int'(all_free), 0);
    check("jump_pulses", pulses, 1);

    // Reset in the middle of operation, asserted between clock edges.
    repeat (6) step(8'h3F);
    check("mid_parked_before", int'(parked), 6);
    #2 rst_n = 1'b0;
    #1 check_reset_state("mid_rst");
    check("mid_rst_sum", int'(parked) + int'(empty), NB);
    @(negedge clk);
    check_reset_state("mid_rst_hold");
    rst_n = 1'b1;
    restart_scoreboard();
    repeat (6) step(8'h3F);
    check("mid_parked_after", int'(parked), 6);
    check("mid_pulses", pulses, 1);

    // Random vectors, checked every cycle by the scoreboard.
    for (int i = 0; i < 1000; i++) begin
      step(8'($urandom_range(0, 255)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
